wb_port_arbiter: RTL
====================

// Module: wb_port_arbiter
// PURPOSE
//  Shares the single register-file write port between the in-order pipeline writeback
//  and a long-latency unit (mul/div). Pipeline writeback arrives from the MEM/WB register;
//  its data is already selected by mem_to_reg.
//  Long-unit results are buffered in a small FIFO. The pipeline has priority, and a
//  starvation counter stalls MEM/WB for one cycle to drain the FIFO.
//  Sits between MEM/WB and the register file, in the WB stage.
// PARAMETERS
//  XLEN          32  datapath width
//  DEPTH         2   long-unit result FIFO entries (>=1)
//  STARVE_LIMIT  4   cycles a non-empty FIFO waits before the pipeline is stalled (>=1)
// PORTS
//  clk                 in   1     clock, rising edge
//  reset               in   1     asynchronous, active-high
//  in_wb_write_enable  in   1     MEM/WB write request
//  in_wb_rd            in   5     MEM/WB destination register
//  in_wb_data          in   XLEN  MEM/WB writeback data
//  in_lu_valid         in   1     long-unit result valid
//  in_lu_rd            in   5     long-unit destination register
//  in_lu_data          in   XLEN  long-unit result
//  out_lu_ready        out  1     FIFO can accept a result this cycle
//  out_stall_wb        out  1     MEM/WB must hold; its current write is NOT performed
//  out_rf_we           out  1     register-file write enable
//  out_rf_rd           out  5     register-file write address
//  out_rf_data         out  XLEN  register-file write data
//  out_grant_lu        out  1     this cycle's write comes from the FIFO
//  out_lu_pending      out  1     FIFO non-empty (decode uses it for RAW/WAW interlock)
// BEHAVIOUR
//  - State: FIFO (count 0..DEPTH, head/tail pointers that wrap modulo DEPTH) and starve_cnt (0..STARVE_LIMIT).
//  - Reset (async): count=0, pointers=0, starve_cnt=0.
//    While reset is high, every output is 0 except out_lu_ready=0.
//    Reset in mid-operation discards buffered results.
//  - pw = in_wb_write_enable && in_wb_rd!=0. A write to x0 never uses the port.
//  - out_lu_ready = (count<DEPTH); it is combinational from registered state only.
//    There is no same-cycle credit for a pop.
//  - Enqueue when in_lu_valid && out_lu_ready && in_lu_rd!=0.
//    A handshaked result with rd=0 is consumed and dropped.
//  - No bypass: an enqueued result is written at the earliest on the next cycle.
//  - Arbitration (combinational, each cycle):
//      grant_lu = count>0 && (!pw || starve_cnt==STARVE_LIMIT)
//      grant_lu : rf_we=1, rf_rd/rf_data = FIFO head, pop; out_stall_wb = pw
//      else pw  : rf_we=1, rf_rd/rf_data = in_wb_*; out_stall_wb = 0
//      else     : rf_we=0, rf_rd=0, rf_data=0
//  - Enqueue and pop in the same cycle: count is unchanged and both pointers advance.
//  - starve_cnt: cleared on pop or when count==0.
//    Otherwise, if count>0, it increments and saturates at STARVE_LIMIT.
//    A starvation grant therefore happens after at most STARVE_LIMIT consecutive pipeline writes.
//  - out_stall_wb is asserted for exactly one cycle per starvation grant.
//    MEM/WB re-presents the same write on the next cycle, and starve_cnt is 0 then,
//    so the pipeline wins.
//  - FIFO entries are written in arrival order.
//  - Decode must not issue an instruction that reads or writes a register with an
//    outstanding long-unit result while out_lu_pending=1. This block does not check rd collisions.
//  - out_lu_pending = (count!=0).
// TESTING
//  1. reset high with in_lu_valid=1 -> all outputs 0; after release, out_lu_ready=1 and count=0.
//  2. Only pw (rd=5, data=0xDEADBEEF) -> same cycle rf_we=1, rf_rd=5, rf_data=0xDEADBEEF,
//     stall=0; rd=0 with we=1 -> rf_we=0.
//  3. LU result rd=7, 0x1234 at cycle t with pipeline idle -> cycle t+1: rf_we=1, grant_lu=1,
//     rf_rd=7; pending drops at t+2.
//  4. FIFO holds one entry plus continuous pw -> pipeline writes for 4 cycles.
//     Cycle 5: grant_lu=1, stall_wb=1, FIFO entry written. Cycle 6: held pipeline write completes.
//  5. DEPTH=2: three back-to-back LU results while pw is busy -> third sees ready=0.
//     After a pop, ready=1 the next cycle; writes appear in order, with pointer wrap checked.
//  6. Assert reset with 2 entries pending -> pending=0 immediately; no stale write after release.

Source files
------------

// File: rtl/wb_port_arbiter_if.sv
// Bundle of the writeback-port arbiter's bus signals: MEM/WB request, long-unit
// result handshake and the register-file write port.
interface wb_port_arbiter_if #(
  parameter int XLEN = 32
);
  logic            in_wb_write_enable;
  logic [4:0]      in_wb_rd;
  logic [XLEN-1:0] in_wb_data;
  logic            in_lu_valid;
  logic [4:0]      in_lu_rd;
  logic [XLEN-1:0] in_lu_data;
  logic            out_lu_ready;
  logic            out_stall_wb;
  logic            out_rf_we;
  logic [4:0]      out_rf_rd;
  logic [XLEN-1:0] out_rf_data;
  logic            out_grant_lu;
  logic            out_lu_pending;

  modport master (
    output in_wb_write_enable, in_wb_rd, in_wb_data, in_lu_valid, in_lu_rd, in_lu_data,
    input  out_lu_ready, out_stall_wb, out_rf_we, out_rf_rd, out_rf_data,
           out_grant_lu, out_lu_pending
  );

  modport slave (
    input  in_wb_write_enable, in_wb_rd, in_wb_data, in_lu_valid, in_lu_rd, in_lu_data,
    output out_lu_ready, out_stall_wb, out_rf_we, out_rf_rd, out_rf_data,
           out_grant_lu, out_lu_pending
  );
endinterface

// File: rtl/wb_port_arbiter.sv
// Shares the register-file write port between pipeline writeback (priority) and a
// FIFO of long-unit results; a starvation counter forces a one-cycle WB stall to drain.
module wb_port_arbiter #(
  parameter int XLEN         = 32,
  parameter int DEPTH        = 2,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  wb_port_arbiter_if.slave       bus
);
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int STV_W = $clog2(STARVE_LIMIT + 1);

  typedef struct packed {
    logic [4:0]      rd;
    logic [XLEN-1:0] data;
  } entry_t;

  entry_t           mem [DEPTH];
  logic [PTR_W-1:0] head, tail;
  logic [CNT_W-1:0] count;
  logic [STV_W-1:0] starve_cnt;

  logic pw, not_full, starved, push, pop;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  always_comb begin
    pw       = bus.in_wb_write_enable && (bus.in_wb_rd != 5'd0);
    not_full = (count < CNT_W'(DEPTH));
    starved  = (starve_cnt == STV_W'(STARVE_LIMIT));
    pop      = (count != '0) && (!pw || starved);
    // A handshaked rd=0 result is acknowledged through ready but never stored.
    push     = bus.in_lu_valid && not_full && (bus.in_lu_rd != 5'd0);
  end

  // NOTE: every output gets a default before any branch, so no latch is inferred.
  always_comb begin
    bus.out_lu_ready   = 1'b0;
    bus.out_lu_pending = 1'b0;
    bus.out_grant_lu   = 1'b0;
    bus.out_stall_wb   = 1'b0;
    bus.out_rf_we      = 1'b0;
    bus.out_rf_rd      = 5'd0;
    bus.out_rf_data    = '0;
    if (!reset) begin
      bus.out_lu_ready   = not_full;
      bus.out_lu_pending = (count != '0);
      bus.out_grant_lu   = pop;
      if (pop) begin
        bus.out_rf_we   = 1'b1;
        bus.out_rf_rd   = mem[head].rd;
        bus.out_rf_data = mem[head].data;
        bus.out_stall_wb = pw;
      end else if (pw) begin
        bus.out_rf_we   = 1'b1;
        bus.out_rf_rd   = bus.in_wb_rd;
        bus.out_rf_data = bus.in_wb_data;
      end
    end
  end

  // NOTE: the result storage has no reset; count gates every read, so stale data is never seen.
  always_ff @(posedge clk) begin
    if (push) mem[tail] <= '{rd: bus.in_lu_rd, data: bus.in_lu_data};
  end

  // NOTE: sequential state uses non-blocking assignments so all updates see pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      head       <= '0;
      tail       <= '0;
      count      <= '0;
      starve_cnt <= '0;
    end else begin
      if (push) tail <= ptr_inc(tail);
      if (pop)  head <= ptr_inc(head);
      if (push && !pop)      count <= count + CNT_W'(1);
      else if (pop && !push) count <= count - CNT_W'(1);
      if (pop || count == '0) starve_cnt <= '0;
      else if (!starved)      starve_cnt <= starve_cnt + STV_W'(1);
    end
  end
endmodule
